// File: rtl/regfile_seq_pkg.sv
`default_nettype none
// ============================================================================
// regfile_seq_pkg
// Shared types for the 8085 register-pair file sequencer.
// Revision: 1.0
// ============================================================================
package regfile_seq_pkg;

  localparam int OP_W  = 3;
  localparam int SEL_W = 3;
  localparam int STB_W = 6;

  localparam int STB_RREG_RD = 0;
  localparam int STB_LREG_RD = 1;
  localparam int STB_RREG_WR = 2;
  localparam int STB_LREG_WR = 3;
  localparam int STB_DREG_RD = 4;
  localparam int STB_DREG_WR = 5;

  typedef enum logic [OP_W-1:0] {
    OP_RD_LO   = 3'd0,
    OP_RD_HI   = 3'd1,
    OP_RD_PAIR = 3'd2,
    OP_WR_LO   = 3'd3,
    OP_WR_HI   = 3'd4,
    OP_WR_PAIR = 3'd5,
    OP_INCDEC  = 3'd6,
    OP_ADDR    = 3'd7
  } op_e;

  typedef enum logic [SEL_W-1:0] {
    SEL_BC = 3'd0,
    SEL_DE = 3'd1,
    SEL_HL = 3'd2,
    SEL_WZ = 3'd3,
    SEL_PC = 3'd4,
    SEL_SP = 3'd5
  } sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_STRB  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel <= SEL_W'(SEL_SP);
  endfunction

  function automatic logic is_two_phase(input op_e op);
    return op inside {OP_RD_PAIR, OP_WR_PAIR, OP_INCDEC};
  endfunction

  // Pair ops and INCDEC use the low/read strobe first, the high/write strobe second.
  function automatic logic [STB_W-1:0] strobe_for(input op_e op, input logic second);
    logic [STB_W-1:0] s;
    s = '0;
    case (op)
      OP_RD_LO:   s[STB_RREG_RD] = 1'b1;
      OP_RD_HI:   s[STB_LREG_RD] = 1'b1;
      OP_RD_PAIR: s[second ? STB_LREG_RD : STB_RREG_RD] = 1'b1;
      OP_WR_LO:   s[STB_RREG_WR] = 1'b1;
      OP_WR_HI:   s[STB_LREG_WR] = 1'b1;
      OP_WR_PAIR: s[second ? STB_LREG_WR : STB_RREG_WR] = 1'b1;
      OP_INCDEC:  s[second ? STB_DREG_WR : STB_DREG_RD] = 1'b1;
      OP_ADDR:    s[STB_DREG_RD] = 1'b1;
      default:    s = '0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_seq_timer.sv
`default_nettype none
// ============================================================================
// regfile_seq_timer
// Loadable down-counter; expire_o is high while the count equals 1.
// Revision: 1.0
// ============================================================================
module regfile_seq_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q > W'(1)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// regfile_sequencer
// Expands register-pair commands into registered select/mode/strobe waveforms.
// Revision: 1.0
// ============================================================================
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int SETUP    = 1,
  parameter int STROBE_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_dec,
  input  logic             cmd_two,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             bc_rw,
  output logic             de_rw,
  output logic             hl_rw,
  output logic             wz_rw,
  output logic             pc_rw,
  output logic             sp_rw,
  output logic             rreg_rd,
  output logic             lreg_rd,
  output logic             rreg_wr,
  output logic             lreg_wr,
  output logic             dreg_rd,
  output logic             dreg_wr,
  output logic             dreg_inc,
  output logic             dreg_dec,
  output logic             dreg_cnt,
  output logic             dreg_cnt2
);

  localparam int DWELL_MAX = (SETUP > STROBE_W) ? SETUP : STROBE_W;
  localparam int TW        = $clog2(DWELL_MAX + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             dec_q, dec_d, two_q, two_d, phase_q, phase_d;
  logic             tmr_load, tmr_expire;
  logic [TW-1:0]    tmr_value;

  logic [5:0]       rw_q, rw_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [3:0]       mode_q, mode_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    dec_d   = dec_q;
    two_d   = two_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = op_e'(cmd_op);
          sel_d   = cmd_sel;
          dec_d   = cmd_dec;
          two_d   = cmd_two;
          phase_d = 1'b0;
          state_d = sel_legal(cmd_sel) ? ST_SETUP : ST_DONE;
        end
      end
      ST_SETUP: if (tmr_expire) state_d = ST_STRB;
      ST_STRB:  if (tmr_expire) state_d = ST_GAP;
      ST_GAP: begin
        if (phase_q || !is_two_phase(op_q)) begin
          state_d = ST_DONE;
        end else begin
          phase_d = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every state entry reloads the dwell; GAP and DONE are single-cycle.
  assign tmr_load  = (state_d != state_q);
  assign tmr_value = (state_d == ST_SETUP) ? TW'(SETUP)    :
                     (state_d == ST_STRB)  ? TW'(STROBE_W) : TW'(1);

  regfile_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  // Outputs are decoded from next-state values so the flops line up with the state.
  always_comb begin
    rw_d    = '0;
    stb_d   = '0;
    mode_d  = '0;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_DONE) && !sel_legal(sel_d);
    if (state_d inside {ST_SETUP, ST_STRB, ST_GAP}) begin
      case (sel_d)
        SEL_BC:  rw_d[0] = 1'b1;
        SEL_DE:  rw_d[1] = 1'b1;
        SEL_HL:  rw_d[2] = 1'b1;
        SEL_WZ:  rw_d[3] = 1'b1;
        SEL_PC:  rw_d[4] = 1'b1;
        SEL_SP:  rw_d[5] = 1'b1;
        default: rw_d    = '0;
      endcase
      if (op_d == OP_INCDEC) mode_d = {!dec_d, dec_d, !two_d, two_d};
      if (state_d == ST_STRB) stb_d = strobe_for(op_d, phase_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD_LO;
      sel_q   <= '0;
      dec_q   <= 1'b0;
      two_q   <= 1'b0;
      phase_q <= 1'b0;
      rw_q    <= '0;
      stb_q   <= '0;
      mode_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      dec_q   <= dec_d;
      two_q   <= two_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      stb_q   <= stb_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw} = rw_q;
  assign rreg_rd   = stb_q[STB_RREG_RD];
  assign lreg_rd   = stb_q[STB_LREG_RD];
  assign rreg_wr   = stb_q[STB_RREG_WR];
  assign lreg_wr   = stb_q[STB_LREG_WR];
  assign dreg_rd   = stb_q[STB_DREG_RD];
  assign dreg_wr   = stb_q[STB_DREG_WR];
  assign {dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2} = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// tb_regfile_sequencer
// Scoreboard bench: per-cycle expected output vectors from the timing formulas.
// Revision: 1.0
// ============================================================================
module tb_regfile_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] cmd_op, cmd_sel;
  logic       cmd_dec, cmd_two, v0, v1;

  // Vector layout: {ready, busy, done, err, rw[5:0] (bit=sel), strobes[5:0], inc, dec, cnt, cnt2}
  logic       r0, b0, d0, e0, r1, b1, d1, e1;
  logic [5:0] rw0, st0, rw1, st1;
  logic [3:0] md0, md1;
  logic [19:0] obs0, obs1;
  assign obs0 = {r0, b0, d0, e0, rw0, st0, md0};
  assign obs1 = {r1, b1, d1, e1, rw1, st1, md1};

  regfile_sequencer u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(r0),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_dec(cmd_dec), .cmd_two(cmd_two),
    .busy(b0), .done(d0), .err(e0),
    .bc_rw(rw0[0]), .de_rw(rw0[1]), .hl_rw(rw0[2]), .wz_rw(rw0[3]), .pc_rw(rw0[4]), .sp_rw(rw0[5]),
    .rreg_rd(st0[0]), .lreg_rd(st0[1]), .rreg_wr(st0[2]), .lreg_wr(st0[3]),
    .dreg_rd(st0[4]), .dreg_wr(st0[5]),
    .dreg_inc(md0[3]), .dreg_dec(md0[2]), .dreg_cnt(md0[1]), .dreg_cnt2(md0[0])
  );

  regfile_sequencer #(.SETUP(2), .STROBE_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(r1),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_dec(cmd_dec), .cmd_two(cmd_two),
    .busy(b1), .done(d1), .err(e1),
    .bc_rw(rw1[0]), .de_rw(rw1[1]), .hl_rw(rw1[2]), .wz_rw(rw1[3]), .pc_rw(rw1[4]), .sp_rw(rw1[5]),
    .rreg_rd(st1[0]), .lreg_rd(st1[1]), .rreg_wr(st1[2]), .lreg_wr(st1[3]),
    .dreg_rd(st1[4]), .dreg_wr(st1[5]),
    .dreg_inc(md1[3]), .dreg_dec(md1[2]), .dreg_cnt(md1[1]), .dreg_cnt2(md1[0])
  );

  typedef struct {
    logic [19:0] v;
    int          id;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int   total = 0;
  int   bad   = 0;
  int   cmd_id = 0;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int num_cycles(input int op, input int sel, input int su, input int sw);
    int p;
    if (sel > 5) return 2;
    p = (op == 2 || op == 5 || op == 6) ? 2 : 1;
    return p * (su + sw + 1) + 2;
  endfunction

  // Expected outputs in cycle c after the accept edge.
  function automatic logic [19:0] exp_vec(input int op, input int sel, input bit dec, input bit two,
                                          input int c, input int su, input int sw);
    logic [19:0] v;
    int p, l, k, r, s;
    v = '0;
    if (sel > 5) begin
      if (c == 1) begin
        v[18] = 1'b1; v[17] = 1'b1; v[16] = 1'b1;
      end else begin
        v[19] = 1'b1;
      end
      return v;
    end
    p = (op == 2 || op == 5 || op == 6) ? 2 : 1;
    l = su + sw + 1;
    if (c <= p * l) begin
      v[18] = 1'b1;
      v[10 + sel] = 1'b1;
      if (op == 6) v[3:0] = {!dec, dec, !two, two};
      k = (c - 1) / l;
      r = (c - 1) % l + 1;
      if (r > su && r <= su + sw) begin
        case (op)
          0: s = 0;
          1: s = 1;
          2: s = k;
          3: s = 2;
          4: s = 3;
          5: s = 2 + k;
          7: s = 4;
          default: s = 4 + k;
        endcase
        v[4 + s] = 1'b1;
      end
    end else if (c == p * l + 1) begin
      v[18] = 1'b1; v[17] = 1'b1;
    end else begin
      v[19] = 1'b1;
    end
    return v;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      m0 = q0.pop_front();
      check($sformatf("d0 cmd%0d cyc%0d", m0.id, m0.c), obs0, m0.v);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      m1 = q1.pop_front();
      check($sformatf("d1 cmd%0d cyc%0d", m1.id, m1.c), obs1, m1.v);
    end
  end

  task automatic issue(input bit inst, input int op, input int sel, input bit dec, input bit two,
                       input bit drop);
    int su, sw, n;
    bit ok;
    su = inst ? 2 : 1;
    sw = inst ? 3 : 1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((inst ? r1 : r0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("ready wait d%0d cmd%0d", inst, cmd_id), {19'd0, ok}, 20'd1);
    cmd_op  = op[2:0];
    cmd_sel = sel[2:0];
    cmd_dec = dec;
    cmd_two = two;
    if (inst) v1 = 1'b1; else v0 = 1'b1;
    n = num_cycles(op, sel, su, sw);
    for (int c = 1; c <= n; c++) begin
      if (inst) q1.push_back(exp_t'{v: exp_vec(op, sel, dec, two, c, su, sw), id: cmd_id, c: c});
      else      q0.push_back(exp_t'{v: exp_vec(op, sel, dec, two, c, su, sw), id: cmd_id, c: c});
    end
    cmd_id++;
    @(posedge clk);
    @(negedge clk);
    if (drop) begin
      if (inst) v1 = 1'b0; else v0 = 1'b0;
      cmd_op  = 3'($urandom);
      cmd_sel = 3'($urandom);
      cmd_dec = 1'($urandom);
      cmd_two = 1'($urandom);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    check("drain timeout", {19'd0, ok}, 20'd1);
  endtask

  initial begin
    v0 = 1'b0; v1 = 1'b0;
    cmd_op = '0; cmd_sel = '0; cmd_dec = 1'b0; cmd_two = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset d0", obs0, 20'h00000);
    check("reset d1", obs1, 20'h00000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready after reset d0", obs0, 20'h80000);
    check("ready after reset d1", obs1, 20'h80000);

    issue(1'b0, 0, 2, 1'b0, 1'b0, 1'b1);  // RD_LO HL
    issue(1'b1, 5, 5, 1'b0, 1'b0, 1'b1);  // WR_PAIR SP, SETUP=2 STROBE_W=3
    issue(1'b0, 6, 4, 1'b1, 1'b1, 1'b1);  // INCDEC PC, dec by 2
    issue(1'b0, 2, 7, 1'b0, 1'b0, 1'b1);  // RD_PAIR illegal sel
    issue(1'b0, 7, 0, 1'b0, 1'b0, 1'b0);  // ADDR BC, valid held
    issue(1'b0, 7, 1, 1'b0, 1'b0, 1'b1);  // ADDR DE back-to-back
    drain();

    // Reset in cycle 2 of RD_PAIR HL.
    @(negedge clk);
    cmd_op = 3'd2; cmd_sel = 3'd2; cmd_dec = 1'b0; cmd_two = 1'b0;
    v0 = 1'b1;
    q0.push_back(exp_t'{v: exp_vec(2, 2, 1'b0, 1'b0, 1, 1, 1), id: cmd_id, c: 1});
    cmd_id++;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    @(posedge clk);
    #3;
    check("rst pre cyc2", obs0, exp_vec(2, 2, 1'b0, 1'b0, 2, 1, 1));
    rst = 1'b1;
    #1;
    check("rst async clear", obs0, 20'h00000);
    repeat (2) @(posedge clk);
    #1;
    check("rst held no done", obs0, 20'h00000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst release ready", obs0, 20'h80000);

    issue(1'b0, 1, 2, 1'b0, 1'b0, 1'b1);  // RD_HI HL after reset

    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
